// File: rtl/register_dump_unit.sv
// Debug register dump: takes over bank read port A, walks every register and
// streams each word MSB-first as bytes to the UART transmitter.
module register_dump_unit #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned N_REGS  = 32,
    parameter int unsigned NB_BYTE = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [NB_DATA-1:0] data_reg_i,
    input  logic               tx_done_i,
    output logic               select_debug_o,
    output logic [NB_REG-1:0]  addr_reg_debug_o,
    output logic               tx_start_o,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned BYTES_PER_REG = NB_DATA / NB_BYTE;
    localparam int unsigned NB_CNT        = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
    localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BYTES_PER_REG - 1);
    localparam logic [NB_REG-1:0] LAST_IDX  = NB_REG'(N_REGS - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SET_ADDR = 3'd1;
    localparam logic [2:0] LATCH    = 3'd2;
    localparam logic [2:0] SEND     = 3'd3;
    localparam logic [2:0] WAIT_TX  = 3'd4;
    localparam logic [2:0] NEXT     = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    logic [2:0]         state, state_nxt;
    logic [NB_REG-1:0]  idx, idx_nxt;
    logic [NB_DATA-1:0] shift, shift_nxt;
    logic [NB_CNT-1:0]  cnt, cnt_nxt;
    logic               sel_nxt;

    // Next-state and datapath update
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        shift_nxt = shift;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start_i) begin
                    idx_nxt   = '0;
                    state_nxt = SET_ADDR;
                end
            end
            SET_ADDR: state_nxt = LATCH;
            LATCH: begin
                shift_nxt = data_reg_i;
                cnt_nxt   = '0;
                state_nxt = SEND;
            end
            SEND: state_nxt = WAIT_TX;
            WAIT_TX: begin
                if (tx_done_i) begin
                    if (cnt == LAST_BYTE) begin
                        state_nxt = NEXT;
                    end else begin
                        shift_nxt = {shift[NB_DATA-NB_BYTE-1:0], {NB_BYTE{1'b0}}};
                        cnt_nxt   = cnt + NB_CNT'(1);
                        state_nxt = SEND;
                    end
                end
            end
            NEXT: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    idx_nxt   = idx + NB_REG'(1);
                    state_nxt = SET_ADDR;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        sel_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state            <= IDLE;
            idx              <= '0;
            shift            <= '0;
            cnt              <= '0;
            select_debug_o   <= 1'b0;
            addr_reg_debug_o <= '0;
            tx_start_o       <= 1'b0;
            tx_data_o        <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            state            <= state_nxt;
            idx              <= idx_nxt;
            shift            <= shift_nxt;
            cnt              <= cnt_nxt;
            select_debug_o   <= sel_nxt;
            addr_reg_debug_o <= (state_nxt == IDLE) ? '0 : idx_nxt;
            tx_start_o       <= (state_nxt == SEND);
            if (state_nxt == SEND) begin
                tx_data_o <= shift_nxt[NB_DATA-1 -: NB_BYTE];
            end
            busy_o           <= (state_nxt != IDLE);
            done_o           <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_register_dump_unit.sv
// Self-checking bench for register_dump_unit: bank model, UART responder,
// byte scoreboard and per-cycle output monitor.
module tb_register_dump_unit;

    localparam int NREG      = 32;
    localparam int NBYTES    = 4 * NREG;
    localparam int BUDGET    = 5000;
    // Inclusive cycle count from the start-sampling cycle through the done cycle
    localparam int DONE_LAT  = 1 + 11 * NREG + 1;

    logic        clock_i;
    logic        reset_i;
    logic        start_i;
    logic [31:0] data_reg_i;
    logic        tx_done_i;
    logic        select_debug_o;
    logic [4:0]  addr_reg_debug_o;
    logic        tx_start_o;
    logic [7:0]  tx_data_o;
    logic        busy_o;
    logic        done_o;

    logic [31:0] bank [NREG];
    logic [12:0] sb [$];

    int vectors, miscompares;
    int n_starts, done_cnt, cyc;
    int start_cyc, first_start_cyc, done_cyc;
    int tx_delay;
    bit stray_en;

    register_dump_unit dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .data_reg_i       (data_reg_i),
        .tx_done_i        (tx_done_i),
        .select_debug_o   (select_debug_o),
        .addr_reg_debug_o (addr_reg_debug_o),
        .tx_start_o       (tx_start_o),
        .tx_data_o        (tx_data_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    assign data_reg_i = bank[addr_reg_debug_o];

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    task automatic push_dump();
        logic [31:0] w;
        for (int r = 0; r < NREG; r++) begin
            w = bank[r];
            for (int b = 0; b < 4; b++) begin
                sb.push_back({5'(r), w[31-8*b -: 8]});
            end
        end
    endtask

    task automatic start_dump();
        start_i = 1'b1;
        @(posedge clock_i);
        #2;
        start_cyc = cyc;
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clock_i);
            #2;
            if (done_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Per-cycle output monitor; pops the scoreboard on every tx_start
    task automatic monitor();
        logic [12:0] e;
        logic [7:0]  last_byte;
        bit          have_last;
        bit          first;
        int          prev_reg, last_start, exp_gap;
        have_last = 1'b0;
        prev_reg  = 0;
        last_start = 0;
        last_byte = '0;
        forever begin
            @(posedge clock_i);
            cyc++;
            #1;
            if (tx_start_o === 1'b1) begin
                n_starts++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_tx_start: got byte %02h at cycle %0d, required no tx_start", tx_data_o, cyc);
                end else begin
                    first = (sb.size() % NBYTES == 0);
                    e = sb.pop_front();
                    if (tx_data_o !== e[7:0]) begin
                        miscompares++;
                        $display("FAIL tx_data: got %02h required %02h (reg %0d)", tx_data_o, e[7:0], e[12:8]);
                    end
                    vectors++;
                    if (addr_reg_debug_o !== e[12:8] || select_debug_o !== 1'b1) begin
                        miscompares++;
                        $display("FAIL addr_sel_on_send: got addr %0d sel %b required addr %0d sel 1", addr_reg_debug_o, select_debug_o, e[12:8]);
                    end
                    if (first) begin
                        first_start_cyc = cyc;
                    end else begin
                        exp_gap = (int'(e[12:8]) == prev_reg) ? tx_delay + 1 : tx_delay + 4;
                        vectors++;
                        if (cyc - last_start != exp_gap) begin
                            miscompares++;
                            $display("FAIL tx_start_gap: got %0d cycles required %0d", cyc - last_start, exp_gap);
                        end
                    end
                    prev_reg = int'(e[12:8]);
                end
                last_start = cyc;
                last_byte  = tx_data_o;
                have_last  = 1'b1;
            end else if (busy_o === 1'b1 && have_last) begin
                vectors++;
                if (tx_data_o !== last_byte) begin
                    miscompares++;
                    $display("FAIL tx_data_stable: got %02h required %02h", tx_data_o, last_byte);
                end
            end
            if (done_o === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                vectors++;
                if (select_debug_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL select_on_done: got %b required 0", select_debug_o);
                end
            end else if (busy_o === 1'b1) begin
                vectors++;
                if (select_debug_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL select_while_busy: got %b required 1", select_debug_o);
                end
            end
            if (busy_o !== 1'b1) have_last = 1'b0;
        end
    endtask

    // UART model: tx_done_i pulses tx_delay cycles after each tx_start;
    // in stray mode it also pulses during SEND and stretches into NEXT
    task automatic responder();
        int k;
        k = 0;
        forever begin
            if (tx_start_o === 1'b1) begin
                if (stray_en) tx_done_i = 1'b1;
                @(posedge clock_i);
                #1;
                tx_done_i = 1'b0;
                repeat (tx_delay - 1) @(posedge clock_i);
                #1;
                tx_done_i = 1'b1;
                @(posedge clock_i);
                #1;
                if (stray_en && (k % 4 == 3)) begin
                    @(posedge clock_i);
                    #1;
                end
                tx_done_i = 1'b0;
                k++;
            end else begin
                @(posedge clock_i);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(posedge clock_i);
        #2;
        vectors++;
        if ({select_debug_o, tx_start_o, busy_o, done_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags: got sel/start/busy/done %b%b%b%b required 0000", select_debug_o, tx_start_o, busy_o, done_o);
        end
        vectors++;
        if (addr_reg_debug_o !== 5'd0 || tx_data_o !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: got addr %0d data %02h required 0 00", addr_reg_debug_o, tx_data_o);
        end
        reset_i = 1'b0;
        @(posedge clock_i);
        #2;
    endtask

    task automatic test_dump(input int delay, input bit check_latency);
        bit ok;
        tx_delay = delay;
        done_cnt = 0;
        n_starts = 0;
        push_dump();
        start_dump();
        wait_done(1, ok);
        repeat (20) @(posedge clock_i);
        #2;
        vectors++;
        if (!ok || done_cnt != 1) begin
            miscompares++;
            $display("FAIL dump_done_count: got %0d required 1 (delay %0d)", done_cnt, delay);
        end
        vectors++;
        if (n_starts != NBYTES || sb.size() != 0) begin
            miscompares++;
            $display("FAIL dump_byte_count: got %0d starts, %0d left required %0d, 0", n_starts, sb.size(), NBYTES);
        end
        if (check_latency) begin
            vectors++;
            if (first_start_cyc - start_cyc != 2) begin
                miscompares++;
                $display("FAIL first_tx_latency: got %0d edges required 2", first_start_cyc - start_cyc);
            end
            vectors++;
            if (done_cyc - start_cyc + 2 != DONE_LAT) begin
                miscompares++;
                $display("FAIL done_latency: got %0d cycles required %0d", done_cyc - start_cyc + 2, DONE_LAT);
            end
        end
        sb.delete();
    endtask

    task automatic test_stray();
        bit ok;
        tx_delay = 3;
        stray_en = 1'b1;
        done_cnt = 0;
        n_starts = 0;
        push_dump();
        start_dump();
        repeat (40) @(posedge clock_i);
        #2;
        start_i = 1'b1;
        @(posedge clock_i);
        #2;
        start_i = 1'b0;
        wait_done(1, ok);
        repeat (30) @(posedge clock_i);
        #2;
        stray_en = 1'b0;
        vectors++;
        if (!ok || done_cnt != 1) begin
            miscompares++;
            $display("FAIL stray_done_count: got %0d required 1", done_cnt);
        end
        vectors++;
        if (n_starts != NBYTES || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stray_byte_count: got %0d starts, %0d left required %0d, 0", n_starts, sb.size(), NBYTES);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        ok = 1'b0;
        tx_delay = 10;
        done_cnt = 0;
        n_starts = 0;
        push_dump();
        start_dump();
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clock_i);
            #2;
            if (n_starts >= 23) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reach_reg5_byte2: got %0d starts required 23", n_starts);
        end
        // one cycle on, the unit is waiting for register 5 byte [15:8]
        @(posedge clock_i);
        #2;
        reset_i = 1'b1;
        @(posedge clock_i);
        #2;
        vectors++;
        if ({select_debug_o, tx_start_o, busy_o, done_o} !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_flags: got sel/start/busy/done %b%b%b%b required 0000", select_debug_o, tx_start_o, busy_o, done_o);
        end
        vectors++;
        if (addr_reg_debug_o !== 5'd0 || tx_data_o !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_data: got addr %0d data %02h required 0 00", addr_reg_debug_o, tx_data_o);
        end
        reset_i = 1'b0;
        sb.delete();
        repeat (25) @(posedge clock_i);
        #2;
        vectors++;
        if (n_starts != 23 || done_cnt != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got %0d starts %0d done required 23 0", n_starts, done_cnt);
        end
        test_dump(1, 1'b1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int second_start;
        tx_delay = 1;
        done_cnt = 0;
        n_starts = 0;
        push_dump();
        push_dump();
        start_i = 1'b1;
        wait_done(1, ok);
        @(posedge clock_i);
        @(posedge clock_i);
        #2;
        second_start = cyc;
        start_i = 1'b0;
        wait_done(2, ok);
        repeat (20) @(posedge clock_i);
        #2;
        vectors++;
        if (!ok || done_cnt != 2) begin
            miscompares++;
            $display("FAIL b2b_done_count: got %0d required 2", done_cnt);
        end
        vectors++;
        if (n_starts != 2 * NBYTES || sb.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_byte_count: got %0d starts, %0d left required %0d, 0", n_starts, sb.size(), 2 * NBYTES);
        end
        vectors++;
        if (first_start_cyc - second_start != 2) begin
            miscompares++;
            $display("FAIL b2b_restart_latency: got %0d edges required 2", first_start_cyc - second_start);
        end
        sb.delete();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        n_starts = 0;
        done_cnt = 0;
        cyc = 0;
        start_cyc = 0;
        first_start_cyc = 0;
        done_cyc = 0;
        tx_delay = 1;
        stray_en = 1'b0;
        reset_i = 1'b1;
        start_i = 1'b0;
        tx_done_i = 1'b0;
        for (int i = 0; i < NREG; i++) bank[i] = 32'hA0B0_C000 + 32'(i);
        fork
            monitor();
            responder();
        join_none
        test_reset();
        test_dump(1, 1'b1);
        test_dump(10, 1'b0);
        test_stray();
        test_reset_mid_dump();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
